// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and types for the FIFO-to-stream read adapter.
package fifo_rd_stream_pkg;

  // Output buffer depth. The read-credit check and the buffer both size from this.
  localparam int BUF_DEPTH = 2;

  // Occupancy count of the output buffer (0..BUF_DEPTH).
  typedef logic [1:0] occ_t;

  // True when another read may be issued. The count is words already held plus
  // the word still in flight from the FIFO, minus the beat leaving this cycle.
  // A beat can only be accepted when occupancy is non-zero, so the subtraction
  // never wraps.
  function automatic logic credit_ok(input occ_t occ, input logic infl, input logic acc);
    logic [2:0] cnt;
    cnt = 3'(occ) + 3'(infl);
    cnt = cnt - 3'(acc);
    return cnt < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// Two-entry output buffer: entry 0 is the head and drives the stream outputs.
module fifo_rd_stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DWIDTH = 64
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DWIDTH-1:0] head_o,
  output logic              head_vld_o,
  output logic [1:0]        occ_o
);

  logic [DWIDTH-1:0] ent0_q, ent0_d;
  logic [DWIDTH-1:0] ent1_q, ent1_d;
  occ_t              occ_q, occ_d;
  logic              vld_q, vld_d;
  logic              do_push, do_pop;

  // Next-state: shift on pop, fill the first free slot on push. A push that
  // coincides with a pop lands behind whatever remains so order is kept.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    occ_d   = occ_q;
    do_pop  = pop_i && (occ_q != occ_t'(0));
    // The credit logic keeps pushes off a full buffer; refusing one here
    // anyway means a bad upstream cannot corrupt stored words.
    do_push = push_i && ((occ_q < occ_t'(BUF_DEPTH)) || do_pop);
    unique case ({do_push, do_pop})
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - occ_t'(1);
      end
      2'b10: begin
        if (occ_q == occ_t'(0)) ent0_d = push_data_i;
        else                    ent1_d = push_data_i;
        occ_d = occ_q + occ_t'(1);
      end
      2'b11: begin
        if (occ_q == occ_t'(1)) begin
          ent0_d = push_data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data_i;
        end
      end
      default: ;
    endcase
    vld_d = (occ_d != occ_t'(0));
  end

  // Buffer state; reset clears the head so data_o reads zero during reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
      vld_q  <= vld_d;
    end
  end

  assign head_o     = ent0_q;
  assign head_vld_o = vld_q;
  assign occ_o      = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Adapts a FIFO read port (show-ahead or registered-q) to a valid/ready stream
// with a last marker every PKT_LEN beats.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DWIDTH    = 64,
  parameter int SHOWAHEAD = 1,
  parameter int PKT_LEN   = 16
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o
);

  localparam int             CW       = $clog2(PKT_LEN) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_LEN - 1);

  logic          accepted;
  logic          push;
  logic          infl_q;
  logic [1:0]    occ;
  logic [CW-1:0] cnt_q, cnt_d;

  assign accepted = valid_o && ready_i;

  // Read credit: never read an empty FIFO, never read while reset is held,
  // and never let held + in-flight words exceed the buffer depth.
  assign fifo_rdreq_o = !arst_i && !fifo_empty_i && credit_ok(occ_t'(occ), infl_q, accepted);

  if (SHOWAHEAD != 0) begin : g_showahead
    // Data is already on fifo_q_i when the request is made.
    assign infl_q = 1'b0;
    assign push   = fifo_rdreq_o;
  end else begin : g_regq
    // Registered q: the word appears one cycle after the request.
    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) infl_q <= 1'b0;
      else        infl_q <= fifo_rdreq_o;
    end
    assign push = infl_q;
  end

  fifo_rd_stream_buf #(
    .DWIDTH (DWIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .push_i      (push),
    .push_data_i (fifo_q_i),
    .pop_i       (accepted),
    .head_o      (data_o),
    .head_vld_o  (valid_o),
    .occ_o       (occ)
  );

  // Beat counter next-state: advance on each accepted beat, wrap at packet end.
  always_comb begin
    cnt_d = cnt_q;
    if (accepted) begin
      if (cnt_q == LAST_IDX) cnt_d = '0;
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  // Beat counter register; reset restarts counting at beat 0.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last_o = valid_o && (cnt_q == LAST_IDX);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised bench for fifo_rd_stream: an upstream FIFO model plus a word
// scoreboard, run against three configurations in turn.
module tb_fifo_rd_stream;
  localparam int DW = 64;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  logic [DW-1:0] fifo_q = '0;
  logic emp_a = 1'b1;
  logic rdy_a = 1'b0;
  logic [1:0] sel = 2'd0;

  logic [2:0]         rdreq_v, valid_v, last_v, rdy_v, emp_v;
  logic [2:0][DW-1:0] data_v;
  logic               rdreq_a, valid_a, last_a;
  logic [DW-1:0]      data_a;
  int                 pl_a;

  always #5 clk = ~clk;

  // g0: show-ahead, 16 beats; g1: registered q, 16 beats; g2: registered q, 1 beat.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign rdy_v[g] = (sel == 2'(g)) && rdy_a;
    assign emp_v[g] = (sel == 2'(g)) ? emp_a : 1'b1;
    fifo_rd_stream #(
      .DWIDTH    (DW),
      .SHOWAHEAD ((g == 0) ? 1 : 0),
      .PKT_LEN   ((g == 2) ? 1 : 16)
    ) u_dut (
      .clk_i        (clk),
      .arst_i       (arst),
      .fifo_q_i     (fifo_q),
      .fifo_empty_i (emp_v[g]),
      .fifo_rdreq_o (rdreq_v[g]),
      .data_o       (data_v[g]),
      .valid_o      (valid_v[g]),
      .ready_i      (rdy_v[g]),
      .last_o       (last_v[g])
    );
  end

  assign rdreq_a = rdreq_v[sel];
  assign valid_a = valid_v[sel];
  assign last_a  = last_v[sel];
  assign data_a  = data_v[sel];
  assign pl_a    = (sel == 2'd2) ? 1 : 16;

  logic [DW-1:0] upq[$];
  logic [DW-1:0] exp_q[$];
  int n_tot = 0, n_bad = 0, ncyc = 0;
  int beats = 0, beat_idx = 0, n_last = 0, stall_rds = 0;
  int first_rd = -1, first_vl = -1, last_beat = 0;
  int push_left = 0, push_seq = 0;
  logic stall_prev = 1'b0, held_l = 1'b0, rnd = 1'b0, last_rd = 1'b0;
  logic [DW-1:0] held_d = '0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Present the upstream FIFO's flags/data for the active configuration.
  task automatic drive_up();
    emp_a = (upq.size() == 0);
    if (sel == 2'd0) fifo_q = (upq.size() != 0) ? upq[0] : '0;
  endtask

  // One clock: observe at the falling edge, then update inputs after the rise.
  task automatic cyc();
    logic [DW-1:0] w;
    logic rd;
    w = '0;
    @(negedge clk);
    ncyc++;
    rd = rdreq_a;
    last_rd = rd;
    chk("rd_while_empty", 64'(rd & emp_a), 64'd0);
    if (rd) stall_rds++;
    if (rd && first_rd < 0) first_rd = ncyc;
    if (valid_a && first_vl < 0) first_vl = ncyc;
    if (stall_prev) begin
      chk("hold_valid", 64'(valid_a), 64'd1);
      chk("hold_data", data_a, held_d);
      chk("hold_last", 64'(last_a), 64'(held_l));
    end
    if (!valid_a) chk("last_idle", 64'(last_a), 64'd0);
    if (valid_a && rdy_a) begin
      if (exp_q.size() == 0) chk("spurious_beat", 64'd1, 64'd0);
      else chk("data", data_a, exp_q.pop_front());
      chk("last", 64'(last_a), 64'((beat_idx % pl_a) == pl_a - 1));
      if (last_a) n_last++;
      beat_idx++;
      beats++;
      last_beat = ncyc;
    end
    stall_prev = valid_a && !rdy_a;
    held_d = data_a;
    held_l = last_a;
    if (rd && upq.size() != 0) begin
      w = upq.pop_front();
      exp_q.push_back(w);
    end
    chk("occ_le_2", 64'(exp_q.size() <= 2), 64'd1);
    @(posedge clk);
    #1;
    if (sel != 2'd0 && rd) fifo_q = w;
    if (rnd) rdy_a = ($urandom_range(0, 3) != 0);
    if (push_left > 0 && $urandom_range(0, 2) != 0) begin
      upq.push_back({$urandom(), 32'(push_seq)});
      push_seq++;
      push_left--;
    end
    drive_up();
  endtask

  task automatic run_until(input int n, input int budget);
    int k;
    k = 0;
    while (beats < n && k < budget) begin
      cyc();
      k++;
    end
    if (beats < n) chk("timeout_beats", 64'(beats), 64'(n));
  endtask

  // Assert reset, check outputs drop at once, hold for n cycles, release.
  task automatic do_reset(input int n);
    arst = 1'b1;
    #1;
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_last", 64'(last_a), 64'd0);
    chk("rst_data", data_a, 64'd0);
    chk("rst_rdreq", 64'(rdreq_a), 64'd0);
    exp_q.delete();
    beat_idx = 0;
    stall_prev = 1'b0;
    drive_up();
    repeat (n) cyc();
    arst = 1'b0;
    beats = 0; n_last = 0; stall_rds = 0;
    first_rd = -1; first_vl = -1;
  endtask

  initial begin
    #2;
    // Full-rate stream of 0x1..0x20 in both read modes.
    for (int g = 0; g < 2; g++) begin
      sel = 2'(g); rdy_a = 1'b1; rnd = 1'b0;
      upq.delete();
      for (int i = 1; i <= 32; i++) upq.push_back(64'(i));
      do_reset(2);
      run_until(32, 100);
      chk("first_valid_lat", 64'(first_vl - first_rd), (g == 0) ? 64'd1 : 64'd2);
      chk("stream_beats", 64'(beats), 64'd32);
      chk("stream_rate", 64'(last_beat - first_vl), 64'd31);
      chk("stream_lasts", 64'(n_last), 64'd2);
    end

    // Downstream stalled with 5 words queued.
    for (int g = 0; g < 2; g++) begin
      sel = 2'(g); rdy_a = 1'b0;
      upq.delete();
      for (int i = 0; i < 5; i++) upq.push_back(64'(256 + i));
      do_reset(2);
      repeat (10) cyc();
      chk("stall_rdreqs", 64'(stall_rds), 64'd2);
      chk("stall_beats", 64'(beats), 64'd0);
      rdy_a = 1'b1;
      run_until(5, 30);
      chk("stall_drain", 64'(beats), 64'd5);
    end

    // Empty FIFO, one word arrives late.
    sel = 2'd0; rdy_a = 1'b1;
    upq.delete();
    do_reset(2);
    repeat (6) cyc();
    chk("empty_rdreqs", 64'(stall_rds), 64'd0);
    chk("empty_beats", 64'(beats), 64'd0);
    upq.push_back(64'hAB);
    drive_up();
    run_until(1, 10);
    repeat (4) cyc();
    chk("late_word_beats", 64'(beats), 64'd1);

    // Reset after beat 7 of a packet; next packet counts from zero.
    upq.delete();
    for (int i = 1; i <= 64; i++) upq.push_back(64'(i));
    do_reset(2);
    run_until(7, 40);
    do_reset(2);
    cyc();
    chk("rdreq_first_edge", 64'(last_rd), 64'd1);
    run_until(16, 40);
    chk("post_rst_beats", 64'(beats), 64'd16);
    chk("post_rst_lasts", 64'(n_last), 64'd1);

    // Random ready and arrivals: 1000 words at PKT_LEN=1, 300 in each 16-beat mode.
    for (int g = 2; g >= 0; g--) begin
      sel = 2'(g); rnd = 1'b1;
      upq.delete();
      push_left = (g == 2) ? 1000 : 300;
      do_reset(2);
      run_until((g == 2) ? 1000 : 300, 20000);
      chk("rand_beats", 64'(beats), (g == 2) ? 64'd1000 : 64'd300);
      chk("rand_lasts", 64'(n_last), (g == 2) ? 64'd1000 : 64'd18);
      chk("rand_sb_empty", 64'(exp_q.size()), 64'd0);
      chk("rand_up_empty", 64'(upq.size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, bad=%0d", n_bad);
    $fatal(1);
  end

endmodule
